fft_frame_loader: RTL and testbench
===================================

Name: fft_frame_loader

Overview:
Upstream neighbour of batch_fft_top. Accepts a serial stream of signed samples with a valid/ready handshake and stores each sample at its bit-reversed index in a SAMPLE_DEPTH-entry register frame. On frame completion it presents the frame in parallel on o_s18_2048_frame, pulses o_u1_start into the FFT, and holds the frame stable until the FFT reports done. Short frames, marked by i_u1_last, are zero-padded to full depth.

Parameters:
SAMPLE_WIDTH, 18, bits per signed sample
SAMPLE_DEPTH, 2048, samples per frame; power of two, >= 4
ADDR_WIDTH, 11, log2(SAMPLE_DEPTH)

Ports:
clk  input  1  clock
rst_n  input  1  reset; synchronous, active-low
i_u1_valid  input  1  upstream sample valid
o_u1_ready  output  1  loader can accept a sample this cycle
i_s18_din  input  SAMPLE_WIDTH  signed sample
i_u1_last  input  1  marks final sample of a frame; qualified by valid&ready
o_u1_start  output  1  one-cycle pulse: frame complete, drives batch_fft_top i_u1_start
i_u1_fft_done  input  1  from batch_fft_top o_u1_done; releases frame
o_s18_2048_frame  output  SAMPLE_DEPTH x SAMPLE_WIDTH  unpacked array, entry k = frame register k
o_u1_padded  output  1  current frame was zero-padded; valid from o_u1_start until next FILL
o_u1_err  output  1  sticky: frame reached full depth without i_u1_last

Behaviour:
- Reset (rst_n=0 at clk edge): state=FILL, count=0, all frame entries=0, o_u1_ready=0 in reset cycle then 1, o_u1_start=0, o_u1_padded=0, o_u1_err=0. Reset wins over every event, mid-frame included; the partial frame is discarded.
- State FILL: o_u1_ready=1. On valid&ready: frame[bitrev(count)] <= i_s18_din; count++. bitrev reverses ADDR_WIDTH bits (count 1 -> index 1024 at default).
  - Handshake with count=SAMPLE_DEPTH-1: go to FIRE. Set o_u1_err if i_u1_last=0 on that beat.
  - Handshake with i_u1_last=1 and count<SAMPLE_DEPTH-1: go to PAD, count++, o_u1_padded<=1.
- State PAD: o_u1_ready=0. Each cycle frame[bitrev(count)]<=0; count++. After the write at count=SAMPLE_DEPTH-1, go to FIRE. PAD lasts SAMPLE_DEPTH-1-n cycles, where n is the index of the last-flagged sample.
- State FIRE: single cycle. o_u1_start=1, o_u1_ready=0; go to BUSY. Start occurs exactly 1 cycle after the final write (sample or pad). The frame register is fully updated when start is high.
- State BUSY: o_u1_ready=0; frame registers are frozen. On i_u1_fft_done=1, go to FILL with count=0 and o_u1_padded<=0. The first new sample can be accepted the cycle after done.
- i_u1_fft_done outside BUSY is ignored. i_u1_valid while ready=0 is ignored; data is not consumed.
- Frame contents of previous frames are not cleared on FILL entry. Every entry is overwritten by a sample or pad before the next start.
- o_u1_start is registered; no combinational path from inputs to o_u1_start or the frame outputs. o_u1_ready is a decode of registered state only.
- Minimum frame period: SAMPLE_DEPTH + 2 cycles plus FFT latency.

Decomposition:
- Shared package fft_pkg: SAMPLE_WIDTH, SAMPLE_DEPTH, ADDR_WIDTH constants (shared with batch_fft_top); loader state encoding FILL/PAD/FIRE/BUSY.
- One sub-module: fft_bitrev (parameterised ADDR_WIDTH, combinational index reversal), reused by later FFT stages.

Test Plan:
1. SAMPLE_DEPTH=8: stream 10..17 contiguous, last on 17 -> frame = {10,14,12,16,11,15,13,17}, o_u1_start 1 cycle after the 8th beat, o_u1_err=0, o_u1_padded=0.
2. SAMPLE_DEPTH=8: 3 samples 5,6,7 with last on 7 -> 5 PAD cycles, frame[0]=5, frame[4]=6, frame[2]=7, others 0, o_u1_padded=1.
3. Backpressure: valid held high through BUSY -> ready=0, no writes, frame unchanged; accept resumes the cycle after i_u1_fft_done.
4. SAMPLE_DEPTH=8: 8 samples with no last -> start issued, o_u1_err=1, stays 1 across later good frames until reset.
5. Reset asserted after 4 samples -> all frame entries 0, count=0, state FILL; a new full frame then loads correctly.
6. Default 2048: ramp 0..2047 with last -> frame[k]=bitrev11(k) for all k, e.g. frame[1]=1024; done pulse during FILL ignored.

Source files
------------

// File: rtl/fft_pkg.sv
// Constants shared by the FFT datapath blocks and the frame loader state encoding.
package fft_pkg;

    localparam int SAMPLE_WIDTH = 18;
    localparam int SAMPLE_DEPTH = 2048;
    localparam int ADDR_WIDTH   = 11;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_FIRE = 2'd2,
        ST_BUSY = 2'd3
    } loader_state_t;

endpackage

// File: rtl/fft_bitrev.sv
// Combinational bit-reversal of an ADDR_WIDTH-bit index.
module fft_bitrev #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic [ADDR_WIDTH-1:0] idx,
    output logic [ADDR_WIDTH-1:0] rev
);

    always_comb begin
        rev = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            rev[i] = idx[ADDR_WIDTH-1-i];
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-parallel frame loader: writes samples at bit-reversed positions,
// zero-pads short frames, then fires the FFT and holds the frame until done.
module fft_frame_loader #(
    parameter int SAMPLE_WIDTH = fft_pkg::SAMPLE_WIDTH,
    parameter int SAMPLE_DEPTH = fft_pkg::SAMPLE_DEPTH,
    parameter int ADDR_WIDTH   = fft_pkg::ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_u1_valid,
    output logic                           o_u1_ready,
    input  logic signed [SAMPLE_WIDTH-1:0] i_s18_din,
    input  logic                           i_u1_last,
    output logic                           o_u1_start,
    input  logic                           i_u1_fft_done,
    output logic signed [SAMPLE_WIDTH-1:0] o_s18_2048_frame [SAMPLE_DEPTH],
    output logic                           o_u1_padded,
    output logic                           o_u1_err
);

    import fft_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(SAMPLE_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    loader_state_t                  state;
    logic [ADDR_WIDTH-1:0]          count;
    logic [ADDR_WIDTH-1:0]          wr_idx;
    logic                           ready_q;
    logic                           start_q;
    logic                           padded_q;
    logic                           err_q;
    logic                           accept;
    logic signed [SAMPLE_WIDTH-1:0] frame [SAMPLE_DEPTH];

    fft_bitrev #(.ADDR_WIDTH(ADDR_WIDTH)) u_bitrev (
        .idx (count),
        .rev (wr_idx)
    );

    // ready_q is only ever high in FILL, so it doubles as the state qualifier
    assign accept = ready_q & i_u1_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_FILL;
            count    <= '0;
            ready_q  <= 1'b0;
            start_q  <= 1'b0;
            padded_q <= 1'b0;
            err_q    <= 1'b0;
            for (int k = 0; k < SAMPLE_DEPTH; k++) begin
                frame[k] <= '0;
            end
        end else begin
            start_q <= 1'b0;
            case (state)
                ST_FILL: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        frame[wr_idx] <= i_s18_din;
                        count         <= count + ONE;
                        if (count == LAST_IDX) begin
                            state   <= ST_FIRE;
                            start_q <= 1'b1;
                            ready_q <= 1'b0;
                            if (!i_u1_last) begin
                                err_q <= 1'b1;
                            end
                        end else if (i_u1_last) begin
                            state    <= ST_PAD;
                            padded_q <= 1'b1;
                            ready_q  <= 1'b0;
                        end
                    end
                end
                ST_PAD: begin
                    frame[wr_idx] <= '0;
                    count         <= count + ONE;
                    if (count == LAST_IDX) begin
                        state   <= ST_FIRE;
                        start_q <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (i_u1_fft_done) begin
                        state    <= ST_FILL;
                        count    <= '0;
                        padded_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_FILL;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_u1_ready       = ready_q;
    assign o_u1_start       = start_q;
    assign o_u1_padded      = padded_q;
    assign o_u1_err         = err_q;
    assign o_s18_2048_frame = frame;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: an 8-deep instance for protocol scenarios and a
// default 2048-deep instance for the full-size bit-reversed ramp.
module tb_fft_frame_loader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic               v8, last8, done8, ready8, start8, pad8, err8;
    logic signed [17:0] din8;
    logic signed [17:0] frame8 [8];

    logic               v2k, last2k, done2k, ready2k, start2k, pad2k, err2k;
    logic signed [17:0] din2k;
    logic signed [17:0] frame2k [2048];

    fft_frame_loader #(.SAMPLE_WIDTH(18), .SAMPLE_DEPTH(8), .ADDR_WIDTH(3)) d8 (
        .clk(clk), .rst_n(rst_n), .i_u1_valid(v8), .o_u1_ready(ready8),
        .i_s18_din(din8), .i_u1_last(last8), .o_u1_start(start8),
        .i_u1_fft_done(done8), .o_s18_2048_frame(frame8),
        .o_u1_padded(pad8), .o_u1_err(err8)
    );

    fft_frame_loader d2k (
        .clk(clk), .rst_n(rst_n), .i_u1_valid(v2k), .o_u1_ready(ready2k),
        .i_s18_din(din2k), .i_u1_last(last2k), .o_u1_start(start2k),
        .i_u1_fft_done(done2k), .o_s18_2048_frame(frame2k),
        .o_u1_padded(pad2k), .o_u1_err(err2k)
    );

    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic signed [17:0] exp8 [8];
    bit                 exp_err = 1'b0;

    // Reference index reversal done arithmetically on integers
    function automatic int bitrev(input int k, input int bits);
        int r = 0;
        int v = k;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic check_frame8(input string name);
        int bad = 0;
        int first = -1;
        for (int k = 0; k < 8; k++) begin
            if (frame8[k] !== exp8[k]) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d entries differ, entry %0d is %0d, required %0d",
                     name, bad, first, frame8[first], exp8[first]);
        end
    endtask

    task automatic send8(input logic signed [17:0] d, input logic l);
        int guard = 0;
        v8 = 1'b1; din8 = d; last8 = l;
        while (ready8 !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (guard >= 50) begin
            n_fail++;
            $display("FAIL send8_timeout: ready is %b, required 1", ready8);
        end
        @(posedge clk); #1;
        v8 = 1'b0; last8 = 1'b0;
    endtask

    // Streams n samples (last flagged on sample n-1 if use_last) and checks
    // start timing, frame content and flags at the start pulse.
    task automatic run_frame8(input int n, input bit use_last, input bit rnd, input int base);
        logic signed [17:0] s [8];
        int w = 0;
        int exp_w;
        for (int k = 0; k < 8; k++) exp8[k] = '0;
        for (int i = 0; i < n; i++) begin
            s[i] = rnd ? 18'($urandom) : 18'(base + i);
            exp8[bitrev(i, 3)] = s[i];
        end
        for (int i = 0; i < n; i++) send8(s[i], use_last && (i == n - 1));
        if (n == 8 && !use_last) exp_err = 1'b1;
        exp_w = 8 - n;
        while (start8 !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        n_checks++;
        if (start8 !== 1'b1 || w != exp_w) begin
            n_fail++;
            $display("FAIL start_latency: start=%b after %0d cycles, required 1 after %0d", start8, w, exp_w);
        end
        check_frame8("frame_at_start");
        n_checks++;
        if (pad8 !== (n < 8)) begin
            n_fail++;
            $display("FAIL padded: got %b, required %b", pad8, (n < 8));
        end
        n_checks++;
        if (err8 !== exp_err) begin
            n_fail++;
            $display("FAIL err: got %b, required %b", err8, exp_err);
        end
        @(posedge clk); #1;
        n_checks++;
        if (start8 !== 1'b0 || ready8 !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_start: start=%b ready=%b, required 0 0", start8, ready8);
        end
    endtask

    task automatic release8();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 done8 = 1'b1;
        @(posedge clk); #1;
        done8 = 1'b0;
        n_checks++;
        if (ready8 !== 1'b1 || pad8 !== 1'b0) begin
            n_fail++;
            $display("FAIL release: ready=%b padded=%b, required 1 0", ready8, pad8);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        v8 = 0; din8 = '0; last8 = 0; done8 = 0;
        v2k = 0; din2k = '0; last2k = 0; done2k = 0;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) if (frame8[k] !== 18'sd0) bad++;
        n_checks++;
        if (ready8 !== 1'b0 || start8 !== 1'b0 || pad8 !== 1'b0 || err8 !== 1'b0 || bad != 0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b start=%b padded=%b err=%b nonzero=%0d, required all 0",
                     ready8, start8, pad8, err8, bad);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ready8 !== 1'b1 || ready2k !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b/%b, required 1/1", ready8, ready2k);
        end
    endtask

    task automatic test_full_frame();
        run_frame8(8, 1'b1, 1'b0, 10);
        n_checks++;
        if (frame8[1] !== 18'sd14 || frame8[7] !== 18'sd17) begin
            n_fail++;
            $display("FAIL ramp_order: frame[1]=%0d frame[7]=%0d, required 14 17", frame8[1], frame8[7]);
        end
        release8();
    endtask

    task automatic test_short_frame();
        run_frame8(3, 1'b1, 1'b0, 5);
        n_checks++;
        if (frame8[0] !== 18'sd5 || frame8[4] !== 18'sd6 || frame8[2] !== 18'sd7) begin
            n_fail++;
            $display("FAIL short_entries: got %0d %0d %0d, required 5 6 7", frame8[0], frame8[4], frame8[2]);
        end
        release8();
    endtask

    task automatic test_backpressure();
        int bad_ready = 0;
        logic signed [17:0] s;
        run_frame8(8, 1'b1, 1'b1, 0);
        v8 = 1'b1; din8 = 18'sd99; last8 = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready8 !== 1'b0) bad_ready++;
        end
        n_checks++;
        if (bad_ready != 0) begin
            n_fail++;
            $display("FAIL busy_ready: ready high %0d times, required 0", bad_ready);
        end
        check_frame8("frame_frozen");
        done8 = 1'b1;
        @(posedge clk); #1;
        done8 = 1'b0;
        n_checks++;
        if (ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_ready: got %b, required 1", ready8);
        end
        @(posedge clk); #1;
        v8 = 1'b0;
        exp8[0] = 18'sd99;
        check_frame8("first_after_done");
        for (int i = 1; i < 8; i++) begin
            s = 18'($urandom);
            exp8[bitrev(i, 3)] = s;
            send8(s, i == 7);
        end
        n_checks++;
        if (start8 !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_start: got %b, required 1", start8);
        end
        check_frame8("resumed_frame");
        @(posedge clk); #1;
        release8();
    endtask

    task automatic test_no_last();
        run_frame8(8, 1'b0, 1'b1, 0);
        release8();
        run_frame8(5, 1'b1, 1'b1, 0);
        release8();
        run_frame8(8, 1'b1, 1'b1, 0);
        release8();
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        for (int i = 0; i < 4; i++) send8(18'($urandom), 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_err = 1'b0;
        for (int k = 0; k < 8; k++) if (frame8[k] !== 18'sd0) bad++;
        n_checks++;
        if (bad != 0 || err8 !== 1'b0 || ready8 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: nonzero=%0d err=%b ready=%b, required 0 0 0", bad, err8, ready8);
        end
        @(posedge clk); #1;
        run_frame8(8, 1'b1, 1'b1, 0);
        release8();
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 8; f++) begin
            run_frame8($urandom_range(1, 8), 1'b1, 1'b1, 0);
            release8();
        end
    endtask

    task automatic test_default_depth();
        int bad = 0;
        int first = -1;
        int not_ready = 0;
        v2k = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            din2k  = 18'(i);
            last2k = (i == 2047);
            done2k = (i == 100);
            if (ready2k !== 1'b1) not_ready++;
            @(posedge clk); #1;
        end
        v2k = 1'b0; last2k = 1'b0; done2k = 1'b0;
        n_checks++;
        if (not_ready != 0) begin
            n_fail++;
            $display("FAIL big_ready: low on %0d beats, required 0", not_ready);
        end
        n_checks++;
        if (start2k !== 1'b1 || err2k !== 1'b0 || pad2k !== 1'b0) begin
            n_fail++;
            $display("FAIL big_flags: start=%b err=%b padded=%b, required 1 0 0", start2k, err2k, pad2k);
        end
        for (int k = 0; k < 2048; k++) begin
            if (frame2k[k] !== 18'(bitrev(k, 11))) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL big_frame: %0d entries differ, entry %0d is %0d, required %0d",
                     bad, first, frame2k[first], bitrev(first, 11));
        end
        n_checks++;
        if (frame2k[1] !== 18'sd1024) begin
            n_fail++;
            $display("FAIL big_entry1: got %0d, required 1024", frame2k[1]);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_backpressure();
        test_no_last();
        test_reset_mid_frame();
        test_random_frames();
        test_default_depth();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
